// File: rtl/mem_arbiter.sv
// Shares one memory port between instruction fetch and the load/store unit: round-robin grant,
// a single outstanding transaction, and abort with an error pulse when memory stalls.
module mem_arbiter #(
   parameter int unsigned XLEN     = 32,
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            if_req_i,
   input  logic [XLEN-1:0] if_addr_i,
   output logic            if_gnt_o,
   output logic            if_rvalid_o,
   output logic [XLEN-1:0] if_rdata_o,
   input  logic            ls_req_i,
   input  logic            ls_we_i,
   input  logic [XLEN-1:0] ls_addr_i,
   input  logic [XLEN-1:0] ls_wdata_i,
   input  logic [2:0]      ls_len_i,
   output logic            ls_gnt_o,
   output logic            ls_rvalid_o,
   output logic [XLEN-1:0] ls_rdata_o,
   output logic            mem_req_o,
   output logic            mem_we_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_wdata_o,
   output logic [2:0]      mem_len_o,
   input  logic            mem_gnt_i,
   input  logic            mem_rvalid_i,
   input  logic [XLEN-1:0] mem_rdata_i,
   output logic            busy_o,
   output logic            err_o
);

   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

   state_e            state_q, state_d;
   logic              owner_ls_q, owner_ls_d;
   logic              last_ls_q, last_ls_d;
   logic              we_q, we_d;
   logic [XLEN-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [2:0]        len_q, len_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic              if_rvalid_q, if_rvalid_d, ls_rvalid_q, ls_rvalid_d;
   logic [XLEN-1:0]   if_rdata_q, if_rdata_d, ls_rdata_q, ls_rdata_d;
   logic              err_q, err_d;
   logic              busy_q;
   logic              pick_ls;
   logic              issue;
   logic [XLEN-1:0]   resp_data;

   always_comb begin
      state_d     = state_q;
      owner_ls_d  = owner_ls_q;
      last_ls_d   = last_ls_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      err_d       = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      // On a tie, the requester that did not own the previous transaction wins.
      pick_ls     = ls_req_i && (!if_req_i || !last_ls_q);
      resp_data   = we_q ? '0 : mem_rdata_i;

      unique case (state_q)
         StIdle: begin
            if (!rst_i && (if_req_i || ls_req_i)) begin
               ls_gnt_o   = pick_ls;
               if_gnt_o   = !pick_ls;
               owner_ls_d = pick_ls;
               last_ls_d  = pick_ls;
               we_d       = pick_ls && ls_we_i;
               addr_d     = pick_ls ? ls_addr_i : if_addr_i;
               wdata_d    = pick_ls ? ls_wdata_i : '0;
               len_d      = (pick_ls && (ls_len_i inside {3'd1, 3'd2})) ? ls_len_i : 3'd4;
               cnt_d      = '0;
               state_d    = StIssue;
            end
         end
         StIssue, StWait: begin
            cnt_d = cnt_q + CntW'(1);
            if (state_q == StWait && mem_rvalid_i) begin
               if (owner_ls_q) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = resp_data;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = resp_data;
               end
               state_d = StIdle;
            end else if (cnt_q == CntW'(MAX_WAIT - 1)) begin
               if (owner_ls_q) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = '0;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = '0;
               end
               err_d   = 1'b1;
               state_d = StIdle;
            end else if (state_q == StIssue && mem_gnt_i) begin
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         owner_ls_q  <= 1'b0;
         last_ls_q   <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         len_q       <= '0;
         cnt_q       <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_ls_q  <= owner_ls_d;
         last_ls_q   <= last_ls_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
         err_q       <= err_d;
         busy_q      <= (state_d != StIdle);
      end
   end

   // Memory-side fields read as zero whenever no request is presented.
   assign issue       = (state_q == StIssue) && !rst_i;
   assign mem_req_o   = issue;
   assign mem_we_o    = issue && we_q;
   assign mem_addr_o  = issue ? addr_q : '0;
   assign mem_wdata_o = issue ? wdata_q : '0;
   assign mem_len_o   = issue ? len_q : '0;

   assign if_rvalid_o = if_rvalid_q;
   assign ls_rvalid_o = ls_rvalid_q;
   assign if_rdata_o  = if_rdata_q;
   assign ls_rdata_o  = ls_rdata_q;
   assign err_o       = err_q;
   assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus randomized traffic,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arbiter;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned MAX_WAIT = 15;

   logic            clk = 1'b0;
   logic            rst_i;
   logic            if_req_i, ls_req_i, ls_we_i, mem_gnt_i, mem_rvalid_i;
   logic [XLEN-1:0] if_addr_i, ls_addr_i, ls_wdata_i, mem_rdata_i;
   logic [2:0]      ls_len_i;
   logic            if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
   logic [XLEN-1:0] if_rdata_o, ls_rdata_o, mem_addr_o, mem_wdata_o;
   logic            mem_req_o, mem_we_o, busy_o, err_o;
   logic [2:0]      mem_len_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.XLEN(XLEN), .MAX_WAIT(MAX_WAIT)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
      .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
      .ls_len_i(ls_len_i), .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o),
      .ls_rdata_o(ls_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_len_o(mem_len_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
      .busy_o(busy_o), .err_o(err_o)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction-level model: one outstanding transaction, its age since issue, and the
   // registered responses it is due to produce.
   logic            m_busy = 1'b0, m_acc = 1'b0, m_owner_ls = 1'b0, m_last_ls = 1'b0;
   logic            m_we = 1'b0;
   logic [XLEN-1:0] m_addr = '0, m_wdata = '0;
   logic [2:0]      m_len = '0;
   int              m_age = 0;
   logic            e_if_rv = 1'b0, e_ls_rv = 1'b0, e_err = 1'b0;
   logic [XLEN-1:0] e_if_rd = '0, e_ls_rd = '0;
   logic            m_if_gnt = 1'b0, m_ls_gnt = 1'b0;

   always @(negedge clk) begin
      logic xl, xi, xreq, done, tmo;
      logic [XLEN-1:0] d;
      xl = 1'b0;
      xi = 1'b0;
      if (!rst_i && !m_busy && (ls_req_i || if_req_i)) begin
         xl = ls_req_i && (!if_req_i || !m_last_ls);
         xi = !xl;
      end
      m_ls_gnt = xl;
      m_if_gnt = xi;
      xreq = !rst_i && m_busy && !m_acc;
      chk("ls_gnt", ls_gnt_o, xl);
      chk("if_gnt", if_gnt_o, xi);
      chk("mem_req", mem_req_o, xreq);
      chk("mem_we", mem_we_o, xreq && m_we);
      chk("mem_addr", mem_addr_o, xreq ? m_addr : '0);
      chk("mem_wdata", mem_wdata_o, xreq ? m_wdata : '0);
      chk("mem_len", 32'(mem_len_o), xreq ? 32'(m_len) : 32'd0);
      chk("busy", busy_o, m_busy);
      chk("if_rvalid", if_rvalid_o, e_if_rv);
      chk("ls_rvalid", ls_rvalid_o, e_ls_rv);
      chk("if_rdata", if_rdata_o, e_if_rd);
      chk("ls_rdata", ls_rdata_o, e_ls_rd);
      chk("err", err_o, e_err);

      if (rst_i) begin
         m_busy = 1'b0; m_acc = 1'b0; m_last_ls = 1'b0;
         e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0; e_if_rd = '0; e_ls_rd = '0;
      end else begin
         e_if_rv = 1'b0; e_ls_rv = 1'b0; e_err = 1'b0;
         if (!m_busy) begin
            if (xl || xi) begin
               m_busy = 1'b1; m_acc = 1'b0; m_age = 0;
               m_owner_ls = xl; m_last_ls = xl;
               m_we    = xl ? ls_we_i : 1'b0;
               m_addr  = xl ? ls_addr_i : if_addr_i;
               m_wdata = xl ? ls_wdata_i : '0;
               m_len   = (xl && (ls_len_i == 3'd1 || ls_len_i == 3'd2)) ? ls_len_i : 3'd4;
            end
         end else begin
            m_age++;
            done = m_acc && mem_rvalid_i;
            tmo  = !done && (m_age == MAX_WAIT);
            d    = (done && !m_we) ? mem_rdata_i : '0;
            if (done || tmo) begin
               if (m_owner_ls) begin e_ls_rv = 1'b1; e_ls_rd = d; end
               else begin e_if_rv = 1'b1; e_if_rd = d; end
               e_err  = tmo;
               m_busy = 1'b0;
            end else if (!m_acc && mem_gnt_i) begin
               m_acc = 1'b1;
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      if_req_i = 0; ls_req_i = 0; ls_we_i = 0; mem_gnt_i = 0; mem_rvalid_i = 0;
      if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0; ls_len_i = 3'd4; mem_rdata_i = '0;
   endtask

   initial begin
      logic [3:0] seq;
      int got, tmo_at;
      logic [2:0] lens [6];
      lens = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0, 3'd7};

      clear_inputs();
      rst_i = 1;
      step(); step();
      rst_i = 0;
      #1;
      chk("reset_busy", busy_o, 0);
      chk("reset_mem_req", mem_req_o, 0);

      // Single LS load, memory grants at once and answers one cycle later.
      step();
      ls_req_i = 1; ls_addr_i = 32'h100; ls_len_i = 3'd4;
      #1 chk("ld_gnt_c0", ls_gnt_o, 1);
      step();
      ls_req_i = 0; mem_gnt_i = 1;
      #1 chk("ld_memreq_c1", mem_req_o, 1);
      chk("ld_addr_c1", mem_addr_o, 32'h100);
      step();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hDEADBEEF;
      step();
      mem_rvalid_i = 0;
      #1 chk("ld_rvalid_c3", ls_rvalid_o, 1);
      chk("ld_rdata_c3", ls_rdata_o, 32'hDEADBEEF);
      chk("ld_if_rvalid", if_rvalid_o, 0);

      // LS transaction abandoned by a 3-cycle reset while waiting for memory.
      step();
      ls_req_i = 1; ls_addr_i = 32'h300;
      step();
      ls_req_i = 0; mem_gnt_i = 1;
      step();
      mem_gnt_i = 0;
      step();
      rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_outputs",
             {if_rvalid_o, ls_rvalid_o, err_o, busy_o, if_gnt_o, ls_gnt_o, mem_req_o, mem_we_o,
              |mem_addr_o, |mem_wdata_o, |mem_len_o, |if_rdata_o, |ls_rdata_o}, 0);
      end
      rst_i = 0; mem_rvalid_i = 0;

      // Both requesters held high: grants must alternate, starting with LS.
      if_req_i = 1; ls_req_i = 1; if_addr_i = 32'h40; ls_addr_i = 32'h80;
      mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5A5A5;
      seq = '0;
      got = 0;
      for (int c = 0; c < 30 && got < 4; c++) begin
         #1;
         if (ls_gnt_o || if_gnt_o) begin
            seq[got] = ls_gnt_o;
            got++;
         end
         if (got < 4) step();
      end
      chk("tie_count", got, 4);
      chk("tie_order", 32'(seq), 32'h5);
      step();
      if_req_i = 0; ls_req_i = 0;
      step(); step(); step();
      clear_inputs();
      step();

      // Halfword store held on the bus until memory grants it.
      ls_req_i = 1; ls_we_i = 1; ls_addr_i = 32'h202; ls_wdata_i = 32'h1234; ls_len_i = 3'd2;
      #1 chk("st_gnt", ls_gnt_o, 1);
      step();
      ls_req_i = 0; ls_we_i = 0;
      for (int i = 0; i < 3; i++) begin
         if (i == 2) mem_gnt_i = 1;
         #1;
         chk("st_we", mem_we_o, 1);
         chk("st_len", 32'(mem_len_o), 2);
         chk("st_addr", mem_addr_o, 32'h202);
         chk("st_wdata", mem_wdata_o, 32'h1234);
         step();
      end
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hFFFFFFFF;
      #1 chk("st_req_dropped", mem_req_o, 0);
      step();
      mem_rvalid_i = 0;
      #1 chk("st_ack", ls_rvalid_o, 1);
      chk("st_rdata_zero", ls_rdata_o, 0);

      // IF fetch into a memory that never answers.
      step();
      if_req_i = 1; if_addr_i = 32'h400;
      #1 chk("tmo_gnt", if_gnt_o, 1);
      step();
      if_req_i = 0;
      tmo_at = -1;
      for (int k = 0; k < 40; k++) begin
         #1;
         if (err_o) begin
            tmo_at = k;
            break;
         end
         step();
      end
      chk("tmo_cycles", tmo_at, MAX_WAIT);
      chk("tmo_if_rvalid", if_rvalid_o, 1);
      chk("tmo_if_rdata", if_rdata_o, 0);
      chk("tmo_idle", busy_o, 0);

      // Invalid length 3 widens to a word; stray responses while idle go nowhere.
      step();
      ls_req_i = 1; ls_len_i = 3'd3; ls_addr_i = 32'h500;
      step();
      ls_req_i = 0; mem_gnt_i = 1;
      #1 chk("len3_as_4", 32'(mem_len_o), 4);
      step();
      mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h11223344;
      step();
      #1 chk("len3_rdata", ls_rdata_o, 32'h11223344);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("spurious_ls", ls_rvalid_o, 0);
         chk("spurious_if", if_rvalid_o, 0);
      end
      clear_inputs();

      // Randomized traffic; every cycle is checked by the model process.
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int phase;
         step();
         phase = (cyc / 100) % 4;
         rst_i = ($urandom_range(0, 599) == 0);
         if (if_req_i && m_if_gnt) if_req_i = 0;
         if (!if_req_i && $urandom_range(0, 2) == 0) begin
            if_req_i = 1; if_addr_i = $urandom;
         end
         if (ls_req_i && m_ls_gnt) ls_req_i = 0;
         if (!ls_req_i && $urandom_range(0, 2) == 0) begin
            ls_req_i = 1; ls_we_i = 1'($urandom); ls_addr_i = $urandom;
            ls_wdata_i = $urandom; ls_len_i = lens[$urandom_range(0, 5)];
         end
         mem_gnt_i    = (phase == 0) ? 1'b0 : ($urandom_range(0, 9) < 6);
         mem_rvalid_i = (phase == 1) ? 1'b0 : ($urandom_range(0, 9) < 5);
         mem_rdata_i  = $urandom;
      end
      step();
      rst_i = 0;
      clear_inputs();
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
